// File: rtl/fact_sched_if.sv
// fact_sched_if: request, response and engine signals of the fact_sched
// scheduler. "slave" is the scheduler's own view; "master" is the view of
// whatever surrounds it (clients, response sink and the factorial engine).
interface fact_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
);
    // Requester side
    logic [NUM_REQ-1:0]   req_valid;
    logic [4*NUM_REQ-1:0] req_n;
    logic [NUM_REQ-1:0]   req_ready;

    // Shared response channel
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_data;
    logic                 rsp_err;

    // Factorial engine side
    logic                 eng_load;
    logic [3:0]           eng_n;
    logic [31:0]          eng_data;
    logic                 eng_valid;

    // Status
    logic                 busy;

    modport slave (
        input  req_valid, req_n, rsp_ready, eng_data, eng_valid,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               eng_load, eng_n, busy
    );

    modport master (
        output req_valid, req_n, rsp_ready, eng_data, eng_valid,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               eng_load, eng_n, busy
    );
endinterface

// File: rtl/fact_sched.sv
// fact_sched: round-robin front end that shares one iterative factorial
// engine among NUM_REQ requesters. One request is in flight at a time;
// operands 0/1 and operands above MAX_N are answered locally, the rest are
// handed to the engine. Results leave on one response channel with
// backpressure.
//
// Optional build macro FACT_SCHED_TIMEOUT_EN: bounds the WAIT state to
// TIMEOUT_CYCLES cycles and answers with rsp_err = 1 when the engine does
// not report in time. Without it WAIT lasts until eng_valid.
module fact_sched #(
    parameter int NUM_REQ        = 4,
    parameter int IDW            = 2,
    parameter int MAX_N          = 12,
    parameter int TIMEOUT_CYCLES = 32
) (
    input logic        clk,
    input logic        rst,
    fact_sched_if.slave bus
);

    // Reject parameter sets that cannot work at elaboration time.
    if ((NUM_REQ < 2) || (NUM_REQ > 8) || ((1 << IDW) < NUM_REQ) ||
        (MAX_N > 12) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
        $error("fact_sched: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q,   ptr_d;     // round-robin start position
    logic [IDW-1:0] id_q,    id_d;      // requester being served
    logic [3:0]     n_q,     n_d;       // latched operand, also drives eng_n
    logic [31:0]    data_q,  data_d;
    logic           err_q,   err_d;
    logic           valid_q, valid_d;
    logic           load_q,  load_d;
    logic           busy_q,  busy_d;

`ifdef FACT_SCHED_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

    // Arbitration results
    logic               grant_any;
    logic [IDW-1:0]     grant_idx;
    logic [3:0]         grant_n;
    logic [NUM_REQ-1:0] grant_oh;

    // Round-robin pick: lowest valid index at or above the pointer, otherwise
    // the lowest valid index below it. Later loop hits override earlier ones,
    // so scanning downwards leaves the lowest index standing, and the second
    // scan (at/above pointer) overrides the wrap-around candidate.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        grant_any = 1'b0;
        grant_idx = '0;
        grant_n   = '0;
        grant_oh  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (i < int'(ptr_q))) begin
                grant_any = 1'b1;
                grant_idx = IDW'(i);
                grant_n   = bus.req_n[4*i +: 4];
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (i >= int'(ptr_q))) begin
                grant_any = 1'b1;
                grant_idx = IDW'(i);
                grant_n   = bus.req_n[4*i +: 4];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = grant_any && (grant_idx == IDW'(i));
        end
    end

    // Accept is combinational so the handshake completes in the IDLE cycle
    // itself; nothing is offered while reset is held or a request is open.
    assign bus.req_ready = (!rst && (state_q == S_IDLE)) ? grant_oh : '0;

    // Next-state and next-output logic for the scheduler FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        n_d     = n_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef FACT_SCHED_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    id_d  = grant_idx;
                    n_d   = grant_n;
                    ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    if (grant_n <= 4'd1) begin
                        // 0! = 1! = 1, no engine needed
                        data_d  = 32'd1;
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end else if (int'(grant_n) > MAX_N) begin
                        // result would not fit in 32 bits
                        data_d  = 32'd0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end

            S_LAUNCH: begin
                // The load pulse issued in this state clears the engine's
                // previous valid before WAIT starts sampling it.
                state_d = S_WAIT;
`ifdef FACT_SCHED_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end

            S_WAIT: begin
                if (bus.eng_valid) begin
                    data_d  = bus.eng_data;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
`ifdef FACT_SCHED_TIMEOUT_EN
                // A result arriving on the last allowed cycle still wins.
                else if (to_cnt_q == TO_LAST) begin
                    data_d  = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end

            S_RESP: begin
                // valid_q is high throughout RESP, so rsp_ready alone
                // completes the response handshake.
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Outputs are registered versions of the state being entered.
        valid_d = (state_d == S_RESP);
        load_d  = (state_d == S_LAUNCH);
        busy_d  = (state_d != S_IDLE);
    end

    // FSM state, round-robin pointer and all registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before the edge, independent of statement order.
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            n_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef FACT_SCHED_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            n_q     <= n_d;
            data_q  <= data_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
`ifdef FACT_SCHED_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

    assign bus.rsp_valid = valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    assign bus.eng_load  = load_q;
    assign bus.eng_n     = n_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fact_sched.sv
// tb_fact_sched: randomized and directed stimulus for fact_sched with a
// transaction-level reference model. The driver process arbitrates requests
// in the model and pushes the expected response; a separate monitor pops and
// compares on every response handshake. The engine is a behavioural model
// with a configurable compute latency.
`timescale 1ns/1ps
module tb_fact_sched;

    localparam int NUM_REQ        = 4;
    localparam int IDW            = 2;
    localparam int MAX_N          = 12;
    localparam int TIMEOUT_CYCLES = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fact_sched_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

    fact_sched #(
        .NUM_REQ       (NUM_REQ),
        .IDW           (IDW),
        .MAX_N         (MAX_N),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference factorial by plain multiplication.
    function automatic logic [31:0] ref_fact(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int k = 2; k <= n; k++) p = p * 32'(k);
        return p;
    endfunction

    // kind: 0 = answered locally, 1 = engine result, 2 = engine timeout
    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
        int          kind;
        int          acc_cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] op_q[NUM_REQ][$];   // operands each requester still wants served
    int         rdy_mode   = 0;     // 0: rsp_ready = 1, 1: random, 2: held 0
    int         n_exp_load = 0;

    function automatic bit ops_pending();
        for (int i = 0; i < NUM_REQ; i++) if (op_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- Behavioural factorial engine ----------------
    logic        eng_valid_m = 1'b0;
    logic [31:0] eng_data_m  = '0;
    logic [3:0]  eng_op      = '0;
    int          eng_cnt     = 0;
    int          eng_lat     = 0;     // 0 selects a random latency of 1..5
    bit          eng_mute    = 1'b0;  // engine never reports completion
    int          n_loads     = 0;

    assign bus.eng_valid = eng_valid_m;
    assign bus.eng_data  = eng_data_m;

    always @(posedge clk) begin
        if (bus.eng_load) begin
            eng_valid_m <= 1'b0;
            eng_op      <= bus.eng_n;
            eng_cnt     <= (eng_lat > 0) ? eng_lat : int'($urandom_range(5, 1));
            n_loads     <= n_loads + 1;
        end else if (eng_cnt > 0) begin
            if ((eng_cnt == 1) && !eng_mute) begin
                eng_valid_m <= 1'b1;
                eng_data_m  <= ref_fact(int'(eng_op));
            end
            eng_cnt <= eng_cnt - 1;
        end
    end

    // ---------------- Driver and request-side model ----------------
    initial begin : driver
        int ptr;
        bit free;
        ptr  = 0;
        free = 1'b1;
        bus.req_valid = '0;
        bus.req_n     = '0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ptr  = 0;
                free = 1'b1;
                exp_q.delete();
            end else begin : model_step
                int                 w;
                logic [NUM_REQ-1:0] want;
                exp_t               e;
                w    = -1;
                want = '0;
                if (free) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        int i;
                        i = (ptr + k) % NUM_REQ;
                        if ((w < 0) && bus.req_valid[i]) w = i;
                    end
                end
                if (w >= 0) want[w] = 1'b1;
                check("req_ready_grant", 32'(bus.req_ready), 32'(want));
                if (w >= 0) begin
                    int n;
                    n         = int'(op_q[w][0]);
                    e.id      = w;
                    e.acc_cyc = cyc;
                    if (n <= 1) begin
                        e.data = 32'd1; e.err = 1'b0; e.kind = 0;
                    end else if (n > MAX_N) begin
                        e.data = 32'd0; e.err = 1'b1; e.kind = 0;
                    end else if (eng_mute) begin
                        e.data = 32'd0; e.err = 1'b1; e.kind = 2;
                        n_exp_load++;
                    end else begin
                        e.data = ref_fact(n); e.err = 1'b0; e.kind = 1;
                        n_exp_load++;
                    end
                    exp_q.push_back(e);
                    void'(op_q[w].pop_front());
                    ptr  = (w + 1) % NUM_REQ;
                    free = 1'b0;
                end
                if (bus.rsp_valid && bus.rsp_ready) free = 1'b1;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_valid[i]       = (op_q[i].size() != 0);
                bus.req_n[4*i +: 4]    = (op_q[i].size() != 0) ? op_q[i][0] : 4'd0;
            end
            case (rdy_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = ($urandom_range(3, 0) != 0);
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    // ---------------- Response monitor ----------------
    initial begin : monitor
        bit             stall;
        bit             seen;
        logic [IDW-1:0] h_id;
        logic [31:0]    h_data;
        logic           h_err;
        stall = 1'b0;
        seen  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
                seen  = 1'b0;
            end else begin
                if (stall) begin
                    check("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
                    check("rsp_hold_id",    32'(bus.rsp_id),    32'(h_id));
                    check("rsp_hold_data",  bus.rsp_data,       h_data);
                    check("rsp_hold_err",   32'(bus.rsp_err),   32'(h_err));
                end
                stall = 1'b0;
                if (bus.rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                    end else begin
                        if (!seen) begin
                            seen = 1'b1;
                            if (exp_q[0].kind == 0)
                                check("bypass_latency", 32'(cyc - exp_q[0].acc_cyc), 32'd1);
                            else if (exp_q[0].kind == 2)
                                check("timeout_latency", 32'(cyc - exp_q[0].acc_cyc),
                                      32'(2 + TIMEOUT_CYCLES));
                        end
                        if (bus.rsp_ready) begin
                            check("rsp_id",   32'(bus.rsp_id),  32'(exp_q[0].id));
                            check("rsp_data", bus.rsp_data,     exp_q[0].data);
                            check("rsp_err",  32'(bus.rsp_err), 32'(exp_q[0].err));
                            void'(exp_q.pop_front());
                            seen = 1'b0;
                        end else begin
                            stall  = 1'b1;
                            h_id   = bus.rsp_id;
                            h_data = bus.rsp_data;
                            h_err  = bus.rsp_err;
                        end
                    end
                end
            end
        end
    end

    // ---------------- Directed sequencing helpers ----------------
    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || ops_pending()) && (t < budget)) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d responses and pending ops still open after %0d cycles",
                     exp_q.size(), budget);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
        check({tag, "_eng_load"},  32'(bus.eng_load),  32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_rsp_id"},    32'(bus.rsp_id),    32'd0);
        check({tag, "_rsp_data"},  bus.rsp_data,       32'd0);
        check({tag, "_eng_n"},     32'(bus.eng_n),     32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- Main sequence ----------------
    initial begin : main
        int loads_before;
        int t;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single engine request: 5! = 120
        op_q[0].push_back(4'd5);
        wait_drain(100);

        // Locally answered operands: no engine load, 1-cycle latency
        loads_before = n_loads;
        op_q[1].push_back(4'd0);
        op_q[1].push_back(4'd1);
        op_q[1].push_back(4'd13);
        op_q[1].push_back(4'd15);
        wait_drain(100);
        check("bypass_no_load", 32'(n_loads - loads_before), 32'd0);

        // All requesters valid continuously right after reset
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++) op_q[i].push_back(4'(3 + i));
        wait_drain(300);

        // Long backpressure on a 12! result while another request waits
        rdy_mode = 2;
        op_q[2].push_back(4'd12);
        op_q[3].push_back(4'd7);
        t = 0;
        while (!bus.rsp_valid && (t < 50)) begin
            @(posedge clk);
            t++;
        end
        check("bp_rsp_seen", 32'(bus.rsp_valid), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        rdy_mode = 0;
        wait_drain(200);

        // Reset while the engine works on 10!
        eng_lat = 8;
        op_q[0].push_back(4'd10);
        t = 0;
        while (!bus.eng_load && (t < 50)) begin
            @(negedge clk);
            t++;
        end
        check("abort_load_seen", 32'(bus.eng_load), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("abort");
        @(posedge clk);
        #1;
        rst     = 1'b0;
        eng_lat = 0;
        op_q[0].push_back(4'd4);
        wait_drain(100);

        // Random traffic with random backpressure and engine latency
        rdy_mode = 1;
        for (int c = 0; c < 400; c++) begin
            int r;
            r = int'($urandom_range(NUM_REQ - 1, 0));
            if (($urandom_range(2, 0) == 0) && (op_q[r].size() < 3))
                op_q[r].push_back(4'($urandom_range(15, 0)));
            @(posedge clk);
            #1;
        end
        wait_drain(3000);
        rdy_mode = 0;

`ifdef FACT_SCHED_TIMEOUT_EN
        // Engine never answers: timeout response, then normal service resumes
        eng_mute = 1'b1;
        op_q[1].push_back(4'd9);
        wait_drain(200);
        eng_mute = 1'b0;
        op_q[1].push_back(4'd3);
        wait_drain(100);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("eng_load_count", 32'(n_loads), 32'(n_exp_load));
        check("final_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
